// File: rtl/seq_div_dec.sv
// Sequential restoring divider with a companion decrement (m = b - c).
// Handshaked: accept in IDLE, 2W quotient steps in CALC, result held in DONE.
module seq_div_dec #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] p,
  input  logic [W-1:0]   b,
  input  logic           c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] q,
  output logic [W-1:0]   r,
  output logic [W-1:0]   m,
  output logic           dz
);

  localparam int CW = $clog2(2*W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(2*W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [2*W-1:0] shf_q, shf_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   div_q, div_d;
  logic [2*W-1:0] quo_q, quo_d;
  logic [W-1:0]   res_r_q, res_r_d;
  logic [W-1:0]   m_q, m_d;
  logic           dz_q, dz_d;

  // One restoring-division step on the current partial remainder.
  logic [W:0]     part;
  logic           qbit;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] shf_next;

  always_comb begin
    part     = {rem_q, shf_q[2*W-1]};
    qbit     = (part >= {1'b0, div_q});
    // When subtracting, the true difference is below div_q, so W bits hold it.
    rem_next = qbit ? (part[W-1:0] - div_q) : part[W-1:0];
    shf_next = {shf_q[2*W-2:0], qbit};
  end

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    shf_d   = shf_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    res_r_d = res_r_q;
    m_d     = m_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d = b;
          shf_d = p;
          rem_d = '0;
          cnt_d = '0;
          m_d   = b - W'(c);
          if (b == '0) begin
            quo_d   = '1;
            res_r_d = p[W-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        shf_d = shf_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          quo_d   = shf_next;
          res_r_d = rem_next;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shf_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      res_r_q <= '0;
      m_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shf_q   <= shf_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      res_r_q <= res_r_d;
      m_q     <= m_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = quo_q;
  assign r         = res_r_q;
  assign m         = m_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_div_dec.sv
// Scoreboard bench for seq_div_dec at W=2: directed cases, an exhaustive
// sweep, output hold under back-pressure, mid-CALC reset and input scrambling.
module tb_seq_div_dec;

  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic [W-1:0]   b;
  logic           c;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] q;
  logic [W-1:0]   r;
  logic [W-1:0]   m;
  logic           dz;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic [W-1:0]   m;
    logic           dz;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_div_dec #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .m         (m),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int pp, input int bb, input int cc);
    exp_t e;
    e.m = W'(bb - cc);
    if (bb == 0) begin
      e.q   = '1;
      e.r   = W'(pp);
      e.dz  = 1'b1;
      e.lat = 0;
    end else begin
      e.q   = (2*W)'(pp / bb);
      e.r   = W'(pp % bb);
      e.dz  = 1'b0;
      e.lat = 2*W;
    end
    return e;
  endfunction

  // Issue one request, wait for its result, compare, optionally hold it
  // under back-pressure, then release it with in_valid still high.
  task automatic send(input int pp, input int bb, input int cc,
                      input bit scramble, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    p        = (2*W)'(pp);
    b        = W'(bb);
    c        = 1'(cc);
    in_valid = 1'b1;
    sb.push_back(model(pp, bb, cc));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 64) begin
      if (scramble) begin
        p        = (2*W)'($urandom);
        b        = W'($urandom);
        c        = 1'($urandom);
        in_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("q", 32'(q), 32'(e.q));
    check("r", 32'(r), 32'(e.r));
    check("m", 32'(m), 32'(e.m));
    check("dz", 32'(dz), 32'(e.dz));
    check("in_ready_done", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_q", 32'(q), 32'(e.q));
      check("hold_r", 32'(r), 32'(e.r));
      check("hold_m", 32'(m), 32'(e.m));
      check("hold_dz", 32'(dz), 32'(e.dz));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    p         = '0;
    b         = '0;
    c         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_q", 32'(q), 0);
    check("rst_r", 32'(r), 0);
    check("rst_m", 32'(m), 0);
    check("rst_dz", 32'(dz), 0);

    // Directed cases
    send(4'b0110, 2'b10, 1, 1'b0, 0);
    send(4'b0111, 2'b11, 0, 1'b0, 0);
    send(4'b1111, 2'b01, 0, 1'b0, 0);
    send(4'b1001, 2'b00, 1, 1'b0, 0);
    send(4'b0101, 2'b00, 0, 1'b0, 0);
    send(4'b1011, 2'b10, 0, 1'b0, 10);
    send(4'b1101, 2'b00, 1, 1'b0, 3);

    // Reset during the second CALC cycle discards the request.
    send(4'b1110, 2'b11, 1, 1'b0, 0);
    @(negedge clk);
    p        = 4'b0110;
    b        = 2'b10;
    c        = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_q", 32'(q), 0);
    check("midrst_r", 32'(r), 0);
    check("midrst_m", 32'(m), 0);
    check("midrst_dz", 32'(dz), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_pulse", 32'(seen), 0);
    send(4'b1011, 2'b11, 1, 1'b0, 0);

    // Inputs scrambled while the block is busy.
    send(4'b1110, 2'b11, 1, 1'b1, 0);
    send(4'b0111, 2'b10, 0, 1'b1, 2);
    send(4'b1001, 2'b00, 1, 1'b1, 0);

    // Exhaustive sweep of every operand combination.
    for (int pp = 0; pp < (1 << (2*W)); pp++)
      for (int bb = 0; bb < (1 << W); bb++)
        for (int cc = 0; cc < 2; cc++)
          send(pp, bb, cc, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
